// File: rtl/parity_stream_check.sv
// ============================================================================
//  Module      : parity_stream_check
//  Description : 1-deep registered valid/ready stage that checks word parity,
//                flags per-frame errors and keeps a saturating error count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_stream_check #(
    parameter int DATA_W = 8,
    parameter int ODD    = 0,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_par,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic              out_last,
    output logic              frame_done,
    output logic              frame_err,
    output logic [CNT_W-1:0]  err_count,
    input  logic              clr_cnt
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } state_t;

    localparam logic             c_ODD     = (ODD != 0);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    state_t              state_q;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_err_q;
    logic                out_last_q;
    logic                frame_done_q;
    logic                frame_err_q;
    logic                sticky_q;
    logic [CNT_W-1:0]    err_count_q;
    logic [CNT_W-1:0]    err_count_d;

    logic                w_xfer;
    logic                w_err;
    logic                w_cnt_inc;

    assign in_ready  = ~out_valid_q | out_ready;
    assign w_xfer    = in_valid & in_ready;
    // Error when the 1s count of data+parity disagrees with the chosen parity.
    assign w_err     = (^in_data) ^ in_par ^ c_ODD;
    assign w_cnt_inc = w_xfer & w_err;

    always_comb begin
        err_count_d = err_count_q;
        if (clr_cnt) begin
            err_count_d = w_cnt_inc ? c_CNT_ONE : '0;
        end else if (w_cnt_inc && (err_count_q != c_CNT_MAX)) begin
            err_count_d = err_count_q + c_CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_err_q    <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            sticky_q     <= 1'b0;
            err_count_q  <= '0;
        end else begin
            frame_done_q <= 1'b0;
            err_count_q  <= err_count_d;

            if (w_xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= in_data;
                out_err_q   <= w_err;
                out_last_q  <= in_last;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (w_xfer) begin
                case (state_q)
                    IDLE:     if (!in_last) state_q <= IN_FRAME;
                    IN_FRAME: if (in_last)  state_q <= IDLE;
                    default:  state_q <= IDLE;
                endcase

                // frame_err keeps its value until the next frame end.
                if (in_last) begin
                    frame_done_q <= 1'b1;
                    frame_err_q  <= sticky_q | w_err;
                    sticky_q     <= 1'b0;
                end else begin
                    sticky_q     <= sticky_q | w_err;
                end
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_err    = out_err_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign err_count  = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_parity_stream_check.sv
// ============================================================================
//  Module      : tb_parity_stream_check
//  Description : Directed bench for parity_stream_check (even, odd, 2-bit count).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parity_stream_check;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_par;
    logic       in_last;
    logic       out_ready;
    logic       clr_cnt;

    logic       r0_ready, r0_valid, r0_err, r0_last, r0_fdone, r0_ferr;
    logic [3:0] r0_data;
    logic [7:0] r0_cnt;
    logic       r1_ready, r1_valid, r1_err, r1_last, r1_fdone, r1_ferr;
    logic [3:0] r1_data;
    logic [7:0] r1_cnt;
    logic       r2_ready, r2_valid, r2_err, r2_last, r2_fdone, r2_ferr;
    logic [3:0] r2_data;
    logic [1:0] r2_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    parity_stream_check #(.DATA_W(4), .ODD(0), .CNT_W(8)) u_even (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r0_ready),
        .in_data(in_data), .in_par(in_par), .in_last(in_last),
        .out_valid(r0_valid), .out_ready(out_ready), .out_data(r0_data),
        .out_err(r0_err), .out_last(r0_last), .frame_done(r0_fdone),
        .frame_err(r0_ferr), .err_count(r0_cnt), .clr_cnt(clr_cnt)
    );

    parity_stream_check #(.DATA_W(4), .ODD(1), .CNT_W(8)) u_odd (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r1_ready),
        .in_data(in_data), .in_par(in_par), .in_last(in_last),
        .out_valid(r1_valid), .out_ready(out_ready), .out_data(r1_data),
        .out_err(r1_err), .out_last(r1_last), .frame_done(r1_fdone),
        .frame_err(r1_ferr), .err_count(r1_cnt), .clr_cnt(clr_cnt)
    );

    parity_stream_check #(.DATA_W(4), .ODD(0), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r2_ready),
        .in_data(in_data), .in_par(in_par), .in_last(in_last),
        .out_valid(r2_valid), .out_ready(out_ready), .out_data(r2_data),
        .out_err(r2_err), .out_last(r2_last), .frame_done(r2_fdone),
        .frame_err(r2_ferr), .err_count(r2_cnt), .clr_cnt(clr_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic p, input logic l);
        in_valid = v;
        in_data  = d;
        in_par   = p;
        in_last  = l;
    endtask

    task automatic test_reset();
        logic [18:0] obs;
        rst_n = 1'b0;
        #3;
        obs = {r0_valid, r0_data, r0_err, r0_last, r0_fdone, r0_ferr, r0_cnt, r0_ready};
        n_cmp++;
        if (obs !== 19'h00001) begin
            n_bad++;
            $display("FAIL reset_state: got %h want 00001", obs);
        end
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_clean_words();
        logic [3:0] d_tab [3] = '{4'b1010, 4'b1000, 4'b1101};
        logic       p_tab [3] = '{1'b0, 1'b1, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, d_tab[i], p_tab[i], i == 2);
            step();
            n_cmp++;
            if ({r0_valid, r0_data, r0_err} !== {1'b1, d_tab[i], 1'b0}) begin
                n_bad++;
                $display("FAIL clean_word%0d: got v=%b d=%b e=%b want v=1 d=%b e=0",
                         i, r0_valid, r0_data, r0_err, d_tab[i]);
            end
        end
        n_cmp++;
        if ({r0_fdone, r0_ferr, r0_cnt} !== {1'b1, 1'b0, 8'd0}) begin
            n_bad++;
            $display("FAIL clean_frame: got done=%b ferr=%b cnt=%0d want 1 0 0",
                     r0_fdone, r0_ferr, r0_cnt);
        end
        drive(1'b0, 4'b0000, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_frame_err();
        drive(1'b1, 4'b1100, 1'b1, 1'b0);
        step();
        n_cmp++;
        if ({r0_err, r0_fdone, r0_cnt} !== {1'b1, 1'b0, 8'd1}) begin
            n_bad++;
            $display("FAIL bad_word: got err=%b done=%b cnt=%0d want 1 0 1",
                     r0_err, r0_fdone, r0_cnt);
        end
        drive(1'b1, 4'b0000, 1'b0, 1'b1);
        step();
        n_cmp++;
        if ({r0_err, r0_last, r0_fdone, r0_ferr, r0_cnt} !== {4'b0111, 8'd1}) begin
            n_bad++;
            $display("FAIL err_frame_end: got err=%b last=%b done=%b ferr=%b cnt=%0d want 0 1 1 1 1",
                     r0_err, r0_last, r0_fdone, r0_ferr, r0_cnt);
        end
        drive(1'b0, 4'b0000, 1'b0, 1'b0);
        step();
        n_cmp++;
        if ({r0_valid, r0_fdone, r0_ferr} !== 3'b001) begin
            n_bad++;
            $display("FAIL ferr_hold: got v=%b done=%b ferr=%b want 0 0 1",
                     r0_valid, r0_fdone, r0_ferr);
        end
        drive(1'b1, 4'b0011, 1'b0, 1'b0);
        step();
        drive(1'b1, 4'b0001, 1'b1, 1'b1);
        step();
        n_cmp++;
        if ({r0_fdone, r0_ferr, r0_cnt} !== {2'b10, 8'd1}) begin
            n_bad++;
            $display("FAIL next_clean_frame: got done=%b ferr=%b cnt=%0d want 1 0 1",
                     r0_fdone, r0_ferr, r0_cnt);
        end
        drive(1'b0, 4'b0000, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_odd();
        drive(1'b1, 4'b0000, 1'b1, 1'b1);
        step();
        n_cmp++;
        if ({r1_valid, r1_err} !== 2'b10) begin
            n_bad++;
            $display("FAIL odd_good: got v=%b err=%b want 1 0", r1_valid, r1_err);
        end
        drive(1'b1, 4'b0000, 1'b0, 1'b1);
        step();
        n_cmp++;
        if ({r1_valid, r1_err, r1_ferr} !== 3'b111) begin
            n_bad++;
            $display("FAIL odd_bad: got v=%b err=%b ferr=%b want 1 1 1", r1_valid, r1_err, r1_ferr);
        end
        drive(1'b0, 4'b0000, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        clr_cnt   = 1'b1;
        drive(1'b1, 4'b0101, 1'b0, 1'b0);
        step();
        clr_cnt = 1'b0;
        n_cmp++;
        if ({r0_data, r0_err, r0_cnt} !== {4'b0101, 1'b0, 8'd0}) begin
            n_bad++;
            $display("FAIL clr_alone: got d=%b err=%b cnt=%0d want 0101 0 0",
                     r0_data, r0_err, r0_cnt);
        end
        out_ready = 1'b0;
        drive(1'b1, 4'b0110, 1'b1, 1'b1);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({r0_ready, r0_valid, r0_data, r0_fdone, r0_cnt} !== {2'b01, 4'b0101, 1'b0, 8'd0}) begin
                n_bad++;
                $display("FAIL stall_%0d: got rdy=%b v=%b d=%b done=%b cnt=%0d want 0 1 0101 0 0",
                         i, r0_ready, r0_valid, r0_data, r0_fdone, r0_cnt);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (r0_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL release_ready: got %b want 1", r0_ready);
        end
        step();
        n_cmp++;
        if ({r0_data, r0_err, r0_fdone, r0_ferr, r0_cnt} !== {4'b0110, 3'b111, 8'd1}) begin
            n_bad++;
            $display("FAIL release_xfer: got d=%b err=%b done=%b ferr=%b cnt=%0d want 0110 1 1 1 1",
                     r0_data, r0_err, r0_fdone, r0_ferr, r0_cnt);
        end
        drive(1'b0, 4'b0000, 1'b0, 1'b0);
        step();
        n_cmp++;
        if (r0_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL drain: out_valid got %b want 0", r0_valid);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_tab [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        out_ready = 1'b1;
        clr_cnt   = 1'b1;
        drive(1'b0, 4'b0000, 1'b0, 1'b0);
        step();
        clr_cnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'b0001, 1'b0, 1'b1);
            step();
            n_cmp++;
            if (r2_cnt !== exp_tab[i]) begin
                n_bad++;
                $display("FAIL sat_cnt%0d: got %0d want %0d", i, r2_cnt, exp_tab[i]);
            end
        end
        clr_cnt = 1'b1;
        step();
        n_cmp++;
        if (r2_cnt !== 2'd1) begin
            n_bad++;
            $display("FAIL clr_with_err: got %0d want 1", r2_cnt);
        end
        clr_cnt = 1'b0;
        drive(1'b0, 4'b0000, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_reset_mid_frame();
        logic [17:0] obs;
        out_ready = 1'b1;
        drive(1'b1, 4'b0111, 1'b0, 1'b0);
        step();
        drive(1'b0, 4'b0000, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        obs = {r0_valid, r0_data, r0_err, r0_last, r0_fdone, r0_ferr, r0_cnt};
        n_cmp++;
        if (obs !== 18'h0) begin
            n_bad++;
            $display("FAIL async_reset: got %h want 0", obs);
        end
        step();
        #2;
        rst_n = 1'b1;
        drive(1'b1, 4'b0000, 1'b0, 1'b1);
        step();
        n_cmp++;
        if ({r0_err, r0_fdone, r0_ferr, r0_cnt} !== {3'b010, 8'd0}) begin
            n_bad++;
            $display("FAIL post_reset_frame: got err=%b done=%b ferr=%b cnt=%0d want 0 1 0 0",
                     r0_err, r0_fdone, r0_ferr, r0_cnt);
        end
        drive(1'b0, 4'b0000, 1'b0, 1'b0);
        step();
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = 4'b0000;
        in_par    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        clr_cnt   = 1'b0;
        test_reset();
        test_clean_words();
        test_frame_err();
        test_odd();
        test_backpressure();
        test_saturate();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
